// File: rtl/bless_port_allocator.sv
// Two-stage age-based output port allocator for a BLESS deflection router.
// Stage A (combinational, input cycle): eject the oldest local-bound flit and
// inject a local flit into the lowest empty slot, then register the slots (S1).
// Stage B (next cycle): rank the S1 slots oldest-first and grant each a
// productive port in rank order, deflecting flits with no free productive port.
module bless_port_allocator #(
    parameter int AGE_W  = 8,
    parameter int SRC_W  = 4,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          in_valid,
    input  logic [4*AGE_W-1:0]  in_age,
    input  logic [4*SRC_W-1:0]  in_src,
    input  logic [15:0]         in_prod,
    input  logic [3:0]          in_eject,
    input  logic [4*DATA_W-1:0] in_data,
    input  logic                inj_valid,
    output logic                inj_ready,
    input  logic [SRC_W-1:0]    inj_src,
    input  logic [3:0]          inj_prod,
    input  logic [DATA_W-1:0]   inj_data,
    output logic                ej_valid,
    output logic [SRC_W-1:0]    ej_src,
    output logic [DATA_W-1:0]   ej_data,
    output logic [3:0]          out_valid,
    output logic [4*AGE_W-1:0]  out_age,
    output logic [4*SRC_W-1:0]  out_src,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_defl,
    input  logic                defl_clr,
    output logic [15:0]         defl_cnt
);
    localparam int NP    = 4;
    localparam int KEY_W = AGE_W + SRC_W;

    // Priority key: age in the upper bits, src below; equal keys fall back to index.
    logic [NP-1:0][KEY_W-1:0]  w_in_key;
    logic [NP-1:0]             w_ej_sel;
    logic                      w_ej_found;
    logic [1:0]                w_ej_idx;
    logic [NP-1:0]             w_slot_v;
    logic [NP-1:0]             w_inj_sel;
    logic                      w_do_inj;

    logic [NP-1:0]             r_s1_valid;
    logic [NP-1:0][AGE_W-1:0]  r_s1_age;
    logic [NP-1:0][SRC_W-1:0]  r_s1_src;
    logic [NP-1:0][3:0]        r_s1_prod;
    logic [NP-1:0][DATA_W-1:0] r_s1_data;

    logic [NP-1:0][KEY_W-1:0]  w_s1_key;
    logic [NP-1:0][1:0]        w_rank;
    logic [NP-1:0]             w_port_v;
    logic [NP-1:0]             w_port_defl;
    logic [NP-1:0][1:0]        w_port_slot;
    logic [2:0]                w_defl_pop;
    logic [16:0]               w_cnt_sum;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + AGE_W'(1);
    endfunction

    // Build the per-input priority keys.
    always_comb begin
        for (int i = 0; i < NP; i++)
            w_in_key[i] = {in_age[i*AGE_W +: AGE_W], in_src[i*SRC_W +: SRC_W]};
    end

    // Pick the single ejecting flit; >= lets the higher index win a full tie.
    always_comb begin
        logic       found;
        logic [1:0] best;
        found = 1'b0;
        best  = '0;
        for (int i = 0; i < NP; i++) begin
            if (in_valid[i] && in_eject[i] && (!found || w_in_key[i] >= w_in_key[best])) begin
                found = 1'b1;
                best  = i[1:0];
            end
        end
        w_ej_found = found;
        w_ej_idx   = best;
        w_ej_sel   = '0;
        if (found) w_ej_sel[best] = 1'b1;
    end

    // Slots left after eject; the injected flit takes the lowest empty one.
    always_comb begin
        w_slot_v  = in_valid & ~w_ej_sel;
        w_inj_sel = '0;
        for (int i = NP-1; i >= 0; i--) begin
            if (!w_slot_v[i]) begin
                w_inj_sel    = '0;
                w_inj_sel[i] = 1'b1;
            end
        end
    end

    assign inj_ready = ~&w_slot_v;
    assign w_do_inj  = inj_valid & inj_ready;

    // Stage A -> S1 slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= '0;
            r_s1_age   <= '0;
            r_s1_src   <= '0;
            r_s1_prod  <= '0;
            r_s1_data  <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (w_do_inj && w_inj_sel[i]) begin
                    r_s1_valid[i] <= 1'b1;
                    r_s1_age[i]   <= '0;
                    r_s1_src[i]   <= inj_src;
                    r_s1_prod[i]  <= inj_prod;
                    r_s1_data[i]  <= inj_data;
                end else begin
                    r_s1_valid[i] <= w_slot_v[i];
                    r_s1_age[i]   <= in_age[i*AGE_W +: AGE_W];
                    r_s1_src[i]   <= in_src[i*SRC_W +: SRC_W];
                    r_s1_prod[i]  <= in_prod[i*4 +: 4];
                    r_s1_data[i]  <= in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Ejected flit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ej_valid <= 1'b0;
            ej_src   <= '0;
            ej_data  <= '0;
        end else begin
            ej_valid <= w_ej_found;
            ej_src   <= in_src[w_ej_idx*SRC_W +: SRC_W];
            ej_data  <= in_data[w_ej_idx*DATA_W +: DATA_W];
        end
    end

    // Rank each S1 slot by counting the valid slots that beat it.
    always_comb begin
        for (int i = 0; i < NP; i++)
            w_s1_key[i] = {r_s1_age[i], r_s1_src[i]};
        for (int i = 0; i < NP; i++) begin
            w_rank[i] = '0;
            for (int j = 0; j < NP; j++) begin
                if (j != i && r_s1_valid[j] &&
                    (!r_s1_valid[i] || w_s1_key[j] > w_s1_key[i] ||
                     (w_s1_key[j] == w_s1_key[i] && j > i)))
                    w_rank[i] = w_rank[i] + 2'd1;
            end
        end
    end

    // Grant ports in rank order: lowest free productive port, else lowest free port.
    always_comb begin
        logic [NP-1:0] taken;
        logic [NP-1:0] avail;
        logic [NP-1:0] grant;
        logic          defl;
        taken       = '0;
        avail       = '0;
        grant       = '0;
        defl        = 1'b0;
        w_port_v    = '0;
        w_port_defl = '0;
        w_port_slot = '0;
        for (int r = 0; r < NP; r++) begin
            for (int i = 0; i < NP; i++) begin
                if (r_s1_valid[i] && w_rank[i] == r[1:0]) begin
                    avail = r_s1_prod[i] & ~taken;
                    defl  = (avail == '0);
                    if (defl) avail = ~taken;
                    grant = avail & (~avail + NP'(1));
                    taken = taken | grant;
                    for (int j = 0; j < NP; j++) begin
                        if (grant[j]) begin
                            w_port_v[j]    = 1'b1;
                            w_port_defl[j] = defl;
                            w_port_slot[j] = i[1:0];
                        end
                    end
                end
            end
        end
    end

    // Output link registers; age advances one hop, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_defl  <= '0;
            out_age   <= '0;
            out_src   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= w_port_v;
            out_defl  <= w_port_defl;
            for (int j = 0; j < NP; j++) begin
                out_age[j*AGE_W +: AGE_W]    <= age_inc(r_s1_age[w_port_slot[j]]);
                out_src[j*SRC_W +: SRC_W]    <= r_s1_src[w_port_slot[j]];
                out_data[j*DATA_W +: DATA_W] <= r_s1_data[w_port_slot[j]];
            end
        end
    end

    // Deflection count for this output load.
    always_comb begin
        w_defl_pop = '0;
        for (int j = 0; j < NP; j++)
            w_defl_pop = w_defl_pop + {2'b00, w_port_defl[j]};
    end

    assign w_cnt_sum = {1'b0, defl_cnt} + {14'b0, w_defl_pop};

    // Saturating deflection counter; clear wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            defl_cnt <= '0;
        else if (defl_clr)     defl_cnt <= '0;
        else if (w_cnt_sum[16]) defl_cnt <= 16'hFFFF;
        else                   defl_cnt <= w_cnt_sum[15:0];
    end

endmodule

// File: tb/tb_bless_port_allocator.sv
// Bench for bless_port_allocator: directed scenarios plus random traffic,
// all outputs compared each cycle against a slot-list reference model.
module tb_bless_port_allocator;
    typedef struct packed {
        logic        v;
        logic        defl;
        logic [7:0]  age;
        logic [3:0]  src;
        logic [3:0]  prod;
        logic [63:0] data;
    } slot_t;
    typedef slot_t [3:0] slots_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [31:0]  in_age;
    logic [15:0]  in_src;
    logic [15:0]  in_prod;
    logic [3:0]   in_eject;
    logic [255:0] in_data;
    logic         inj_valid;
    logic         inj_ready;
    logic [3:0]   inj_src;
    logic [3:0]   inj_prod;
    logic [63:0]  inj_data;
    logic         ej_valid;
    logic [3:0]   ej_src;
    logic [63:0]  ej_data;
    logic [3:0]   out_valid;
    logic [31:0]  out_age;
    logic [15:0]  out_src;
    logic [255:0] out_data;
    logic [3:0]   out_defl;
    logic         defl_clr;
    logic [15:0]  defl_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    slots_t      m_s1, m_out;
    slot_t       m_ej;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    bless_port_allocator dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_age(in_age), .in_src(in_src), .in_prod(in_prod),
        .in_eject(in_eject), .in_data(in_data),
        .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_src(inj_src),
        .inj_prod(inj_prod), .inj_data(inj_data),
        .ej_valid(ej_valid), .ej_src(ej_src), .ej_data(ej_data),
        .out_valid(out_valid), .out_age(out_age), .out_src(out_src),
        .out_data(out_data), .out_defl(out_defl),
        .defl_clr(defl_clr), .defl_cnt(defl_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic slot_t in_slot(int i);
        slot_t s;
        s.v    = in_valid[i];
        s.defl = 1'b0;
        s.age  = in_age[i*8 +: 8];
        s.src  = in_src[i*4 +: 4];
        s.prod = in_prod[i*4 +: 4];
        s.data = in_data[i*64 +: 64];
        return s;
    endfunction

    // Single number ordering: age, then src, then index.
    function automatic int score(slot_t s, int i);
        return s.v ? (int'(s.age) * 64 + int'(s.src) * 4 + i) : -1;
    endfunction

    function automatic int ej_pick();
        int b = -1;
        int bs = -1;
        for (int i = 0; i < 4; i++)
            if (in_eject[i] && score(in_slot(i), i) > bs) begin
                bs = score(in_slot(i), i);
                b  = i;
            end
        return b;
    endfunction

    function automatic slot_t ej_slot();
        slot_t s = '0;
        int e = ej_pick();
        if (e >= 0) s = in_slot(e);
        return s;
    endfunction

    function automatic int n_free();
        int e = ej_pick();
        int n = 0;
        for (int i = 0; i < 4; i++)
            if (!in_valid[i] || i == e) n++;
        return n;
    endfunction

    function automatic logic m_ready();
        return n_free() > 0;
    endfunction

    function automatic slots_t stage_a();
        slots_t s;
        int e = ej_pick();
        bit placed = 0;
        for (int i = 0; i < 4; i++) s[i] = in_slot(i);
        if (e >= 0) s[e].v = 1'b0;
        if (inj_valid)
            for (int i = 0; i < 4; i++)
                if (!placed && !s[i].v) begin
                    placed = 1;
                    s[i].v = 1'b1; s[i].defl = 1'b0; s[i].age = 8'd0;
                    s[i].src = inj_src; s[i].prod = inj_prod; s[i].data = inj_data;
                end
        return s;
    endfunction

    function automatic slots_t alloc(slots_t s);
        slots_t o = '0;
        bit [3:0] taken = '0;
        bit [3:0] done = '0;
        for (int n = 0; n < 4; n++) begin
            int b = -1;
            int bs = -1;
            for (int i = 0; i < 4; i++)
                if (!done[i] && score(s[i], i) > bs) begin
                    bs = score(s[i], i);
                    b  = i;
                end
            if (b >= 0) begin
                int p = -1;
                bit d = 0;
                done[b] = 1;
                for (int j = 0; j < 4; j++)
                    if (p < 0 && s[b].prod[j] && !taken[j]) p = j;
                if (p < 0) begin
                    d = 1;
                    for (int j = 0; j < 4; j++)
                        if (p < 0 && !taken[j]) p = j;
                end
                taken[p]  = 1;
                o[p]      = s[b];
                o[p].age  = (s[b].age == 8'hFF) ? 8'hFF : s[b].age + 8'd1;
                o[p].defl = d;
            end
        end
        return o;
    endfunction

    function automatic logic [15:0] cnt_next(logic [15:0] c, slots_t o);
        int sum = int'(c);
        for (int j = 0; j < 4; j++) sum += int'(o[j].defl);
        return (sum > 65535) ? 16'hFFFF : 16'(sum);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1  <= '0;
            m_out <= '0;
            m_ej  <= '0;
            m_cnt <= '0;
        end else begin
            m_out <= alloc(m_s1);
            m_cnt <= defl_clr ? 16'h0 : cnt_next(m_cnt, alloc(m_s1));
            m_s1  <= stage_a();
            m_ej  <= ej_slot();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs();
        logic [3:0] ev, ed;
        for (int j = 0; j < 4; j++) begin
            ev[j] = m_out[j].v;
            ed[j] = m_out[j].defl;
        end
        chk("out_valid", out_valid, ev);
        chk("out_defl", out_defl, ed);
        for (int j = 0; j < 4; j++)
            if (m_out[j].v) begin
                chk($sformatf("out_age%0d", j), out_age[j*8 +: 8], m_out[j].age);
                chk($sformatf("out_src%0d", j), out_src[j*4 +: 4], m_out[j].src);
                chk($sformatf("out_data%0d", j), out_data[j*64 +: 64], m_out[j].data);
            end
        chk("ej_valid", ej_valid, m_ej.v);
        if (m_ej.v) begin
            chk("ej_src", ej_src, m_ej.src);
            chk("ej_data", ej_data, m_ej.data);
        end
        chk("defl_cnt", defl_cnt, m_cnt);
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drv_done();
        #1 chk("inj_ready", inj_ready, m_ready());
    endtask

    task automatic clear_in();
        in_valid = '0; in_age = '0; in_src = '0; in_prod = '0; in_eject = '0; in_data = '0;
        inj_valid = 1'b0; inj_src = '0; inj_prod = '0; inj_data = '0; defl_clr = 1'b0;
    endtask

    task automatic set_flit(input int i, input logic [7:0] age, input logic [3:0] src,
                            input logic [3:0] prod, input logic [63:0] data, input logic ej);
        in_valid[i]          = 1'b1;
        in_age[i*8 +: 8]     = age;
        in_src[i*4 +: 4]     = src;
        in_prod[i*4 +: 4]    = prod;
        in_data[i*64 +: 64]  = data;
        in_eject[i]          = ej;
    endtask

    // Called just after a negedge: asserts reset mid-cycle, releases on the next negedge.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 4'b0);
        chk("rst_out_defl", out_defl, 4'b0);
        chk("rst_ej_valid", ej_valid, 1'b0);
        chk("rst_defl_cnt", defl_cnt, 16'h0);
        clear_in();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 15));
            in_valid[i] = 1'($urandom);
            set_flit(i, a, 4'($urandom_range(0, 3)), 4'($urandom),
                     {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0));
            in_valid[i] = 1'($urandom);
        end
        inj_valid = 1'($urandom);
        inj_src   = 4'($urandom);
        inj_prod  = 4'($urandom);
        inj_data  = {$urandom, $urandom};
        defl_clr  = ($urandom_range(0, 15) == 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit found;
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 4'b0);
        chk("reset_ej_valid", ej_valid, 1'b0);
        chk("reset_defl_cnt", defl_cnt, 16'h0);
        rst_n = 1'b1;

        // Single flit, productive port 2
        set_flit(0, 8'd5, 4'd1, 4'b0100, 64'hA1, 1'b0); drv_done();
        tick(); clear_in(); drv_done();
        tick();
        chk("t1_valid", out_valid, 4'b0100);
        chk("t1_age", out_age[23:16], 8'd6);
        chk("t1_defl", out_defl, 4'b0);

        // Older flit wins port 0, younger deflected to port 1
        set_flit(0, 8'd3, 4'd1, 4'b0001, 64'hB0, 1'b0);
        set_flit(1, 8'd9, 4'd2, 4'b0001, 64'hB1, 1'b0); drv_done();
        tick(); clear_in(); drv_done();
        tick();
        chk("t2_valid", out_valid, 4'b0011);
        chk("t2_data0", out_data[63:0], 64'hB1);
        chk("t2_age0", out_age[7:0], 8'd10);
        chk("t2_defl", out_defl, 4'b0010);
        chk("t2_cnt", defl_cnt, 16'd1);

        // Age tie broken by src
        set_flit(0, 8'd7, 4'd2, 4'b1000, 64'hC0, 1'b0);
        set_flit(2, 8'd7, 4'd5, 4'b1000, 64'hC2, 1'b0); drv_done();
        tick(); clear_in(); drv_done();
        tick();
        chk("t3_valid", out_valid, 4'b1001);
        chk("t3_src3", out_src[15:12], 4'd5);
        chk("t3_src0", out_src[3:0], 4'd2);
        chk("t3_defl", out_defl, 4'b0001);

        // Full slots block injection; an eject frees slot 2
        for (int i = 0; i < 4; i++) set_flit(i, 8'(i + 1), 4'(i + 1), 4'(1 << i), 64'(i + 16'hD0), 1'b0);
        inj_valid = 1'b1; inj_src = 4'd15; inj_prod = 4'b0001; inj_data = 64'hEE;
        drv_done();
        chk("t4_ready0", inj_ready, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) set_flit(i, 8'(i + 1), 4'(i + 1), 4'(1 << i), 64'(i + 16'hD0), 1'b0);
        in_eject[2] = 1'b1; in_data[191:128] = 64'hD2D2;
        drv_done();
        chk("t4_ready1", inj_ready, 1'b1);
        tick(); clear_in(); drv_done();
        chk("t4_ej_valid", ej_valid, 1'b1);
        chk("t4_ej_data", ej_data, 64'hD2D2);
        tick();
        found = 0;
        for (int j = 0; j < 4; j++)
            if (out_valid[j] && out_src[j*4 +: 4] == 4'd15 && out_age[j*8 +: 8] == 8'd1) found = 1;
        chk("t4_inj_out", 64'(found), 64'd1);

        // Age saturation
        set_flit(0, 8'hFF, 4'd3, 4'b0001, 64'hF0, 1'b0); drv_done();
        tick(); clear_in(); drv_done();
        tick();
        chk("t5_age_sat", out_age[7:0], 8'hFF);

        // Counter saturation: reset, then flood with all-deflecting flits
        apply_reset(); drv_done();
        for (int k = 0; k < 16383; k++) begin
            tick(); clear_in();
            for (int i = 0; i < 4; i++) set_flit(i, 8'($urandom), 4'($urandom), 4'b0, 64'(k), 1'b0);
            drv_done();
        end
        tick(); clear_in();
        set_flit(0, 8'd1, 4'd1, 4'b0, 64'h1, 1'b0);
        set_flit(1, 8'd2, 4'd1, 4'b0, 64'h2, 1'b0); drv_done();
        tick(); clear_in();
        set_flit(0, 8'd1, 4'd1, 4'b0, 64'h3, 1'b0);
        set_flit(3, 8'd2, 4'd1, 4'b0, 64'h4, 1'b0); drv_done();
        tick(); clear_in(); drv_done();
        chk("t5_cnt_fffe", defl_cnt, 16'hFFFE);
        tick();
        chk("t5_cnt_ffff", defl_cnt, 16'hFFFF);
        set_flit(1, 8'd1, 4'd1, 4'b0, 64'h5, 1'b0); drv_done();
        tick(); clear_in(); defl_clr = 1'b1; drv_done();
        tick();
        chk("t5_clr_defl", out_defl, 4'b0001);
        chk("t5_clr_cnt", defl_cnt, 16'h0);
        clear_in();

        // Reset with flits in S1 and on the outputs
        set_flit(0, 8'd4, 4'd1, 4'b0010, 64'h61, 1'b0); drv_done();
        tick(); set_flit(1, 8'd4, 4'd2, 4'b0100, 64'h62, 1'b0); drv_done();
        tick();
        apply_reset();
        set_flit(2, 8'd0, 4'd6, 4'b1000, 64'h66, 1'b0); drv_done();
        tick(); clear_in(); drv_done();
        chk("t6_empty", out_valid, 4'b0);
        tick();
        chk("t6_valid", out_valid, 4'b1000);
        chk("t6_data", out_data[255:192], 64'h66);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            tick(); clear_in(); rand_inputs(); drv_done();
        end
        tick(); clear_in(); drv_done();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
